// File: rtl/pipeline_controller_if.sv
// Purpose : bundles the decode/execute/memory handshake signals exchanged
//           between the pipeline datapath and pipeline_controller.
// Ports   : slave  - controller side (takes status, drives enables/selects)
//           master - datapath side (drives status, takes enables/selects)
interface pipeline_controller_if;
   logic        complete_instr;
   logic        complete_data;
   logic [15:0] IR;
   logic [15:0] IR_Exec;
   logic [2:0]  psr;
   logic        enable_fetch;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        enable_updatePC;
   logic        br_taken;
   logic        bypass_alu_1;
   logic        bypass_alu_2;
   logic        bypass_mem_1;
   logic        bypass_mem_2;
   logic [1:0]  mem_state;

   modport slave (
      input  complete_instr, complete_data, IR, IR_Exec, psr,
      output enable_fetch, enable_decode, enable_execute, enable_writeback,
             enable_updatePC, br_taken, bypass_alu_1, bypass_alu_2,
             bypass_mem_1, bypass_mem_2, mem_state
   );

   modport master (
      output complete_instr, complete_data, IR, IR_Exec, psr,
      input  enable_fetch, enable_decode, enable_execute, enable_writeback,
             enable_updatePC, br_taken, bypass_alu_1, bypass_alu_2,
             bypass_mem_1, bypass_mem_2, mem_state
   );
endinterface

// File: rtl/pipeline_controller.sv
// Purpose : stage-enable, stall, branch and forwarding control for a
//           five-stage LC-3 style pipeline.
// Ports   : clock - rising-edge clock
//           reset - synchronous active-high reset
//           bus   - pipeline_controller_if.slave: memory/instruction
//                   completion, IR/IR_Exec/psr in; stage enables, br_taken,
//                   bypass selects and memory FSM state out
module pipeline_controller (
   input  logic                        clock,
   input  logic                        reset,
   pipeline_controller_if.slave        bus
);

   localparam int unsigned FILL_W = 3;
   localparam int unsigned BR_W   = 2;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(3);
   localparam logic [BR_W-1:0]   BR_LOAD  = BR_W'(3);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   typedef enum logic [1:0] {
      MS_READ     = 2'd0,
      MS_READ_IND = 2'd1,
      MS_WRITE    = 2'd2,
      MS_IDLE     = 2'd3
   } mem_state_t;

   mem_state_t        r_mem_state;
   mem_state_t        w_mem_next;
   logic [FILL_W-1:0] r_fill;
   logic [BR_W-1:0]   r_br_cnt;

   logic [3:0] w_op_id;
   logic [3:0] w_op_ex;
   logic       w_id_alu, w_id_addand, w_id_ld, w_id_st, w_id_ctl, w_id_fwd;
   logic       w_ex_alu, w_ex_addand, w_ex_ld, w_ex_br, w_ex_jmp;
   logic       w_mem_idle, w_br_idle, w_br_taken;
   logic       w_fetch, w_decode, w_execute;
   logic       w_match_1, w_match_2;
   logic       w_unused_bits;

   assign w_op_id = bus.IR[15:12];
   assign w_op_ex = bus.IR_Exec[15:12];

   // Opcode classes for the instruction in decode and in execute
   assign w_id_alu    = (w_op_id == OP_ADD) || (w_op_id == OP_AND) || (w_op_id == OP_NOT);
   assign w_id_addand = (w_op_id == OP_ADD) || (w_op_id == OP_AND);
   assign w_id_ld     = (w_op_id == OP_LD)  || (w_op_id == OP_LDR) || (w_op_id == OP_LDI);
   assign w_id_st     = (w_op_id == OP_ST)  || (w_op_id == OP_STR) || (w_op_id == OP_STI);
   assign w_id_ctl    = (w_op_id == OP_BR)  || (w_op_id == OP_JMP);
   assign w_id_fwd    = w_id_alu || w_id_ld || w_id_st || (w_op_id == OP_JMP);

   assign w_ex_alu    = (w_op_ex == OP_ADD) || (w_op_ex == OP_AND) || (w_op_ex == OP_NOT);
   assign w_ex_addand = (w_op_ex == OP_ADD) || (w_op_ex == OP_AND);
   assign w_ex_ld     = (w_op_ex == OP_LD)  || (w_op_ex == OP_LDR) || (w_op_ex == OP_LDI);
   assign w_ex_br     = (w_op_ex == OP_BR);
   assign w_ex_jmp    = (w_op_ex == OP_JMP);

   assign w_mem_idle = (r_mem_state == MS_IDLE);
   assign w_br_idle  = (r_br_cnt == '0);

   // Branch resolves in the single cycle the counter sits at its load value
   assign w_br_taken = (r_br_cnt == BR_LOAD) && w_mem_idle &&
                       (w_ex_jmp || (w_ex_br && ((bus.IR_Exec[11:9] & bus.psr) != 3'b000)));

   // Stall priority: memory, then instruction fetch, then control
   assign w_fetch   = w_mem_idle && bus.complete_instr && w_br_idle;
   assign w_decode  = w_fetch && (r_fill >= FILL_W'(1));
   assign w_execute = w_mem_idle && (r_fill >= FILL_W'(2));

   assign bus.enable_fetch     = w_fetch;
   assign bus.enable_decode    = w_decode;
   assign bus.enable_execute   = w_execute;
   assign bus.enable_writeback = w_mem_idle ? (r_fill >= FILL_MAX)
                                            : ((r_mem_state == MS_READ) && bus.complete_data);
   assign bus.enable_updatePC  = w_mem_idle && bus.complete_instr && (w_br_idle || w_br_taken);
   assign bus.br_taken         = w_br_taken;
   assign bus.mem_state        = r_mem_state;

   // Forwarding from the execute-stage destination register
   assign w_match_1 = (bus.IR_Exec[11:9] == bus.IR[8:6]);
   assign w_match_2 = w_id_addand && !bus.IR[5] && (bus.IR_Exec[11:9] == bus.IR[2:0]);

   assign bus.bypass_alu_1 = w_id_fwd && w_ex_alu && w_match_1;
   assign bus.bypass_alu_2 = w_id_fwd && w_ex_addand && w_match_2;
   assign bus.bypass_mem_1 = w_id_fwd && w_mem_idle && w_ex_ld && w_match_1;
   assign bus.bypass_mem_2 = w_id_fwd && w_mem_idle && w_ex_ld && w_match_2;

   assign w_unused_bits = ^{bus.IR[4:3], bus.IR[11:9], bus.IR_Exec[8:0]};

   // Memory FSM next state
   always_comb begin
      w_mem_next = r_mem_state;
      case (r_mem_state)
         MS_IDLE: begin
            if (w_execute) begin
               if ((w_op_ex == OP_LD) || (w_op_ex == OP_LDR))       w_mem_next = MS_READ;
               else if ((w_op_ex == OP_LDI) || (w_op_ex == OP_STI)) w_mem_next = MS_READ_IND;
               else if ((w_op_ex == OP_ST) || (w_op_ex == OP_STR))  w_mem_next = MS_WRITE;
               else                                                 w_mem_next = MS_IDLE;
            end
         end
         MS_READ_IND: begin
            // Indirect address fetched; the opcode still in execute picks the data phase
            if (bus.complete_data) begin
               if (w_op_ex == OP_LDI)      w_mem_next = MS_READ;
               else if (w_op_ex == OP_STI) w_mem_next = MS_WRITE;
               else                        w_mem_next = MS_IDLE;
            end
         end
         MS_READ, MS_WRITE: begin
            if (bus.complete_data) w_mem_next = MS_IDLE;
         end
         default: w_mem_next = MS_IDLE;
      endcase
   end

   // State registers: memory FSM, fill counter, branch counter
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem_state <= MS_IDLE;
         r_fill      <= '0;
         r_br_cnt    <= '0;
      end else begin
         r_mem_state <= w_mem_next;
         if (w_fetch && (r_fill < FILL_MAX)) r_fill <= r_fill + FILL_W'(1);
         if (w_decode && w_id_ctl)           r_br_cnt <= BR_LOAD;
         else if (!w_br_idle && w_mem_idle)  r_br_cnt <= r_br_cnt - BR_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Purpose : directed self-checking bench for pipeline_controller.
module tb_pipeline_controller;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   pipeline_controller_if bus ();

   pipeline_controller u_dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [15:0] NOP = 16'hD000;

   // Packed view: {fetch, decode, execute, writeback, updatePC, mem_state, br_taken}
   logic [7:0] obs_st;
   logic [3:0] obs_byp;
   assign obs_st  = {bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                     bus.enable_writeback, bus.enable_updatePC, bus.mem_state, bus.br_taken};
   assign obs_byp = {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2};

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_st(input string tag, input logic [4:0] en, input logic [1:0] ms,
                         input logic bt);
      logic [7:0] exp_v;
      exp_v = {en, ms, bt};
      n_tests++;
      assert (obs_st === exp_v) else begin
         n_fail++;
         $error("FAIL %s: {f,d,e,w,u,ms,bt} got %b expected %b", tag, obs_st, exp_v);
      end
   endtask

   task automatic chk_byp(input string tag, input logic [3:0] exp_v);
      n_tests++;
      assert (obs_byp === exp_v) else begin
         n_fail++;
         $error("FAIL %s: {alu1,alu2,mem1,mem2} got %b expected %b", tag, obs_byp, exp_v);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.complete_instr = 1'b1;
      bus.complete_data  = 1'b0;
      bus.IR      = NOP;
      bus.IR_Exec = NOP;
      bus.psr     = 3'b000;

      // Reset and pipeline fill
      tick(); #1;
      chk_st("reset", 5'b10001, 2'd3, 1'b0);
      chk_byp("reset_byp", 4'b0000);
      rst = 1'b0; #1;
      chk_st("fill0", 5'b10001, 2'd3, 1'b0);
      tick(); #1; chk_st("fill1", 5'b11001, 2'd3, 1'b0);
      tick(); #1; chk_st("fill2", 5'b11101, 2'd3, 1'b0);
      tick(); #1; chk_st("fill3", 5'b11111, 2'd3, 1'b0);
      tick(); #1; chk_st("fill_sat", 5'b11111, 2'd3, 1'b0);

      // LDI: IDLE -> READ_IND x2 -> READ x2 -> IDLE
      bus.IR_Exec = 16'hA200; #1;
      chk_st("ldi_issue", 5'b11111, 2'd3, 1'b0);
      tick(); #1; chk_st("ldi_ind_a", 5'b00000, 2'd1, 1'b0);
      tick(); bus.complete_data = 1'b1; #1;
      chk_st("ldi_ind_b", 5'b00000, 2'd1, 1'b0);
      tick(); bus.complete_data = 1'b0; #1;
      chk_st("ldi_read_a", 5'b00000, 2'd0, 1'b0);
      tick(); bus.complete_data = 1'b1; bus.IR_Exec = NOP; #1;
      chk_st("ldi_read_wb", 5'b00010, 2'd0, 1'b0);
      tick(); bus.complete_data = 1'b0; #1;
      chk_st("ldi_done", 5'b11111, 2'd3, 1'b0);

      // Taken BRnzp with Z set
      bus.IR = 16'h0E05; bus.psr = 3'b010; #1;
      chk_st("brt_decode", 5'b11111, 2'd3, 1'b0);
      tick(); bus.IR = NOP; bus.IR_Exec = 16'h0E05; #1;
      chk_st("brt_cnt3", 5'b00111, 2'd3, 1'b1);
      tick(); #1; chk_st("brt_cnt2", 5'b00110, 2'd3, 1'b0);
      tick(); #1; chk_st("brt_cnt1", 5'b00110, 2'd3, 1'b0);
      tick(); #1; chk_st("brt_resume", 5'b11111, 2'd3, 1'b0);

      // Not-taken BRn with P set
      bus.IR = 16'h0805; bus.IR_Exec = NOP; bus.psr = 3'b001; #1;
      chk_st("brn_decode", 5'b11111, 2'd3, 1'b0);
      tick(); bus.IR = NOP; bus.IR_Exec = 16'h0805; #1;
      chk_st("brn_cnt3", 5'b00110, 2'd3, 1'b0);
      tick(); #1; chk_st("brn_cnt2", 5'b00110, 2'd3, 1'b0);
      tick(); #1; chk_st("brn_cnt1", 5'b00110, 2'd3, 1'b0);
      tick(); #1; chk_st("brn_resume", 5'b11111, 2'd3, 1'b0);

      // JMP always taken
      bus.IR = 16'hC1C0; bus.IR_Exec = NOP; bus.psr = 3'b000; #1;
      tick(); bus.IR = NOP; bus.IR_Exec = 16'hC1C0; #1;
      chk_st("jmp_cnt3", 5'b00111, 2'd3, 1'b1);
      tick(); tick(); tick(); bus.IR_Exec = NOP; #1;
      chk_st("jmp_resume", 5'b11111, 2'd3, 1'b0);

      // ALU forwarding
      bus.IR_Exec = 16'h1642; bus.IR = 16'h10C3; #1;
      chk_byp("fwd_alu_both", 4'b1100);
      bus.IR = 16'h10E3; #1;
      chk_byp("fwd_alu_imm", 4'b1000);
      bus.IR = 16'hD0C3; #1;
      chk_byp("fwd_invalid_ir", 4'b0000);
      bus.IR = NOP; bus.IR_Exec = NOP;

      // Instruction-memory stall
      tick(); bus.complete_instr = 1'b0; #1;
      chk_st("istall_a", 5'b00110, 2'd3, 1'b0);
      tick(); #1; chk_st("istall_b", 5'b00110, 2'd3, 1'b0);
      tick(); bus.complete_instr = 1'b1; #1;
      chk_st("istall_end", 5'b11111, 2'd3, 1'b0);

      // Load forwarding, then reset in the middle of the access
      bus.IR_Exec = 16'h2200; bus.IR = 16'h1040; #1;
      chk_byp("fwd_mem1", 4'b0010);
      tick(); #1;
      chk_st("ld_read", 5'b00000, 2'd0, 1'b0);
      chk_byp("fwd_mem_busy", 4'b0000);
      rst = 1'b1;
      tick(); #1;
      chk_st("reset_mid_mem", 5'b10001, 2'd3, 1'b0);
      rst = 1'b0; bus.IR = NOP; bus.IR_Exec = NOP; #1;
      tick(); #1; chk_st("refill1", 5'b11001, 2'd3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 complete_instr  input  1  instruction memory has returned the fetched word this cycle.
REQ-004 complete_data  input  1  data memory access completes this cycle.
REQ-005 IR  input  16  instruction currently in decode (decode_out IR bus).
REQ-006 IR_Exec  input  16  instruction currently in execute.
REQ-007 psr  input  3  current N/Z/P flags.
REQ-008 enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC  output  1 each  per-stage advance enables.
REQ-009 br_taken  output  1  redirect PC from the execute-stage target.
REQ-010 bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  output  1 each  forwarding selects for execute operand 1 and operand 2.
REQ-011 mem_state  output  2  memory FSM state: READ=0, READ_IND=1, WRITE=2, IDLE=3.

Function
REQ-012 Opcode is IR[15:12]. ALU ops are ADD=0001, AND=0101, NOT=1001. Loads are LD=0010, LDR=0110, LDI=1010. Stores are ST=0011, STR=0111, STI=1011. Control ops are BR=0000, JMP=1100.
REQ-013 Pipeline fill uses a 3-bit counter that is 0 at reset:
- fill=0 -> only enable_fetch and enable_updatePC are asserted.
- fill=1 -> enable_decode is also asserted.
- fill=2 -> enable_execute is also asserted.
- fill>=3 -> enable_writeback is also asserted.
- The counter saturates at 3.
- The counter increments only in cycles where enable_fetch=1.
REQ-014 Memory FSM leaves IDLE only on a cycle where enable_execute=1:
- IR_Exec is LD/LDR -> READ.
- IR_Exec is LDI/STI -> READ_IND.
- IR_Exec is ST/STR -> WRITE.
- Any other opcode -> stays IDLE.
REQ-015 Memory FSM advances on complete_data=1:
- READ_IND -> READ for LDI, WRITE for STI.
- READ -> IDLE, WRITE -> IDLE.
- With complete_data=0 the state holds indefinitely.
REQ-016 While mem_state!=IDLE:
- enable_fetch, enable_decode, enable_execute and enable_updatePC are 0.
- enable_writeback is 1 only when mem_state=READ and complete_data=1.
- Fill and branch counters freeze.
REQ-017 Control stall:
- Trigger: IR opcode is BR or JMP on a cycle where enable_decode=1.
- Action: a 2-bit branch counter loads 3 at that edge.
- While the counter!=0, enable_fetch=0 and enable_decode=0, and the counter decrements once per cycle in which mem_state=IDLE.
REQ-018 br_taken=1 only while the branch counter=3 and mem_state=IDLE, and only if IR_Exec is JMP, or IR_Exec is BR with (IR_Exec[11:9] & psr)!=0. It is 0 otherwise.
REQ-019 While the branch counter!=0, enable_updatePC equals br_taken. When the counter returns to 0, enable_fetch and enable_updatePC resume the following cycle.
REQ-020 If complete_instr=0 in any cycle, enable_fetch, enable_decode and enable_updatePC are forced to 0 in that cycle. enable_execute, enable_writeback and all FSM/counter state are unaffected.
REQ-021 Stall priority, highest first: memory stall (REQ-016), instruction stall (REQ-020), control stall (REQ-017). A BR/JMP in decode during a memory stall does not load the branch counter until enable_decode=1.
REQ-022 Forwarding outputs are combinational and are all 0 unless IR is an ALU op, load, store or JMP:
- bypass_alu_1 = IR_Exec is ALU op and IR_Exec[11:9]==IR[8:6].
- bypass_alu_2 = IR_Exec is ADD/AND, IR is ADD/AND, IR[5]=0 and IR_Exec[11:9]==IR[2:0].
- bypass_mem_1 and bypass_mem_2 use the same rules with IR_Exec being a load.
- bypass_mem_* are 0 whenever mem_state!=IDLE.
REQ-023 All state (fill counter, branch counter, memory FSM) updates only on the rising edge of clock. All enables are combinational functions of that state plus complete_instr and complete_data.

Reset
REQ-024 While reset=1, at the next edge: fill=0, branch counter=0, mem_state=IDLE(3). The cycle after reset deasserts, enable_fetch=1 and enable_updatePC=1 (given complete_instr=1), with all other enables, br_taken and bypass_* at 0.
REQ-025 reset=1 mid-memory-access or mid-control-stall abandons the operation, and the outputs match REQ-024 on the next cycle.

Verification
REQ-026 Fill: release reset with complete_instr=1 and NOP opcodes -> the enables rise one stage per cycle. All five are 1 from cycle 4.
REQ-027 LDI: IR_Exec=0xA200 executes with complete_data pulsed after 2 cycles in each state -> mem_state goes 3->1->1->0->0->3. enable_writeback=1 only on the READ completion cycle.
REQ-028 Taken branch: IR=0x0E05 (BRnzp), psr=3'b010 -> branch counter 3,2,1. br_taken=1 and enable_updatePC=1 at count 3. Fetch resumes on the cycle after count 1.
REQ-029 Not-taken branch: IR=0x0805 (BRn), psr=3'b001 -> br_taken stays 0 and enable_updatePC=0 for 3 cycles.
REQ-030 Forwarding: IR_Exec=0x1642 (ADD R3,R1,R2), IR=0x10C3 (ADD R0,R3,R3) -> bypass_alu_1=1, bypass_alu_2=1, bypass_mem_*=0.
REQ-031 complete_instr=0 for 2 cycles in steady state -> fetch, decode and updatePC are 0 for those 2 cycles. Execute and writeback stay 1.
